// File: rtl/lv_efuse_if.sv
// lv_efuse_if: load handshake, efuse macro read port and register write port of the efuse loader
interface lv_efuse_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
);
    logic              i_efuse_load_req;
    logic              o_efuse_load_done;
    logic              o_efuse_vld;
    logic              o_efuse_busy;
    logic              o_efuse_rd_en;
    logic [ADDR_W-1:0] o_efuse_addr;
    logic [DATA_W-1:0] i_efuse_rdata;
    logic              o_reg_wr_en;
    logic [ADDR_W-1:0] o_reg_wr_addr;
    logic [DATA_W-1:0] o_reg_wr_data;

    modport slave (
        input  i_efuse_load_req, i_efuse_rdata,
        output o_efuse_load_done, o_efuse_vld, o_efuse_busy, o_efuse_rd_en, o_efuse_addr,
               o_reg_wr_en, o_reg_wr_addr, o_reg_wr_data
    );

    modport master (
        output i_efuse_load_req, i_efuse_rdata,
        input  o_efuse_load_done, o_efuse_vld, o_efuse_busy, o_efuse_rd_en, o_efuse_addr,
               o_reg_wr_en, o_reg_wr_addr, o_reg_wr_data
    );
endinterface

// File: rtl/lv_efuse_loader.sv
// lv_efuse_loader: copies efuse words into the register file and validates the stored XOR checksum
module lv_efuse_loader #(
    parameter int EFUSE_WORD_NUM = 8,
    parameter int EFUSE_DATA_W   = 8,
    parameter int EFUSE_ADDR_W   = $clog2(EFUSE_WORD_NUM),
    parameter int RD_WAIT_CYC    = 4
) (
    input logic       i_clk,
    input logic       i_rst_n,
    lv_efuse_if.slave bus
);
    localparam int CNT_W = $clog2(RD_WAIT_CYC + 1);
    localparam logic [EFUSE_ADDR_W-1:0] LAST_WORD = EFUSE_ADDR_W'(EFUSE_WORD_NUM - 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(RD_WAIT_CYC - 1);

    typedef enum logic [2:0] {IDLE, RD, WR, CHK, DONE} state_t;

    state_t                  state;
    logic [CNT_W-1:0]        cnt;
    logic [EFUSE_DATA_W-1:0] acc;
    logic [EFUSE_DATA_W-1:0] chk;
    logic                    nonzero;

    // Load sequencer; o_efuse_addr doubles as the word index, and the last word is the checksum
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state                 <= IDLE;
            cnt                   <= '0;
            acc                   <= '0;
            chk                   <= '0;
            nonzero               <= 1'b0;
            bus.o_efuse_load_done <= 1'b0;
            bus.o_efuse_vld       <= 1'b0;
            bus.o_efuse_busy      <= 1'b0;
            bus.o_efuse_rd_en     <= 1'b0;
            bus.o_efuse_addr      <= '0;
            bus.o_reg_wr_en       <= 1'b0;
            bus.o_reg_wr_addr     <= '0;
            bus.o_reg_wr_data     <= '0;
        end else begin
            case (state)
                IDLE: if (bus.i_efuse_load_req) begin
                    state             <= RD;
                    cnt               <= CNT_INIT;
                    acc               <= '0;
                    nonzero           <= 1'b0;
                    bus.o_efuse_vld   <= 1'b0;
                    bus.o_efuse_busy  <= 1'b1;
                    bus.o_efuse_rd_en <= 1'b1;
                    bus.o_efuse_addr  <= '0;
                end
                RD: if (cnt == '0) begin
                    state             <= WR;
                    bus.o_efuse_rd_en <= 1'b0;
                    nonzero           <= nonzero | (|bus.i_efuse_rdata);
                    if (bus.o_efuse_addr == LAST_WORD) begin
                        chk <= bus.i_efuse_rdata;
                    end else begin
                        acc               <= acc ^ bus.i_efuse_rdata;
                        bus.o_reg_wr_en   <= 1'b1;
                        bus.o_reg_wr_addr <= bus.o_efuse_addr;
                        bus.o_reg_wr_data <= bus.i_efuse_rdata;
                    end
                end else begin
                    cnt <= cnt - 1'b1;
                end
                WR: begin
                    bus.o_reg_wr_en <= 1'b0;
                    if (bus.o_efuse_addr == LAST_WORD) begin
                        state <= CHK;
                    end else begin
                        state             <= RD;
                        cnt               <= CNT_INIT;
                        bus.o_efuse_rd_en <= 1'b1;
                        bus.o_efuse_addr  <= bus.o_efuse_addr + 1'b1;
                    end
                end
                CHK: begin
                    state                 <= DONE;
                    bus.o_efuse_vld       <= (acc == chk) && nonzero;
                    bus.o_efuse_load_done <= 1'b1;
                end
                DONE: begin
                    state                 <= IDLE;
                    bus.o_efuse_load_done <= 1'b0;
                    bus.o_efuse_busy      <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lv_efuse_loader.sv
// tb_lv_efuse_loader: randomized self-checking bench for the efuse loader against a word-level model
module tb_lv_efuse_loader;
    localparam int N      = 8;
    localparam int DW     = 8;
    localparam int AW     = 3;
    localparam int W      = 4;
    localparam int T_DONE = N * (W + 1) + 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lv_efuse_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    lv_efuse_loader #(
        .EFUSE_WORD_NUM(N),
        .EFUSE_DATA_W(DW),
        .EFUSE_ADDR_W(AW),
        .RD_WAIT_CYC(W)
    ) dut (
        .i_clk(clk),
        .i_rst_n(rst_n),
        .bus(bus)
    );

    logic [DW-1:0] mem [N];
    int   cyc = 0, t0 = 0, acc_cnt = 0, rd_run = 0;
    int   n_chk = 0, n_fail = 0;
    logic prev_rd = 1'b0;
    logic [AW-1:0] prev_addr = '0;
    logic done_vld = 1'b0;
    int   wq_addr[$], wq_data[$], wq_cyc[$], done_q[$], win_len[$], win_addr[$];

    logic [18:0] outs;
    assign outs = {bus.o_efuse_busy, bus.o_efuse_load_done, bus.o_efuse_vld, bus.o_efuse_rd_en,
                   bus.o_efuse_addr, bus.o_reg_wr_en, bus.o_reg_wr_addr, bus.o_reg_wr_data};

    // Macro model: data is only correct after the read has been held for the full access time
    always @(posedge clk) acc_cnt <= bus.o_efuse_rd_en ? acc_cnt + 1 : 0;
    assign bus.i_efuse_rdata = (bus.o_efuse_rd_en && acc_cnt == W - 1) ? mem[bus.o_efuse_addr]
                                                                       : ~mem[bus.o_efuse_addr];

    always @(posedge clk) cyc <= cyc + 1;

    // Record writes, done pulses and read windows relative to the current load start
    always @(negedge clk) begin
        if (bus.o_reg_wr_en) begin
            wq_addr.push_back(int'(bus.o_reg_wr_addr));
            wq_data.push_back(int'(bus.o_reg_wr_data));
            wq_cyc.push_back(cyc - t0);
        end
        if (bus.o_efuse_load_done) begin
            done_q.push_back(cyc - t0);
            done_vld <= bus.o_efuse_vld;
        end
        if (bus.o_efuse_rd_en && prev_rd && bus.o_efuse_addr == prev_addr) begin
            rd_run <= rd_run + 1;
        end else begin
            if (prev_rd) begin
                win_len.push_back(rd_run);
                win_addr.push_back(int'(prev_addr));
            end
            rd_run <= bus.o_efuse_rd_en ? 1 : 0;
        end
        prev_rd   <= bus.o_efuse_rd_en;
        prev_addr <= bus.o_efuse_addr;
    end

    function automatic logic exp_vld();
        logic [DW-1:0] x = '0;
        logic nz = 1'b0;
        for (int k = 0; k < N - 1; k++) x ^= mem[k];
        for (int k = 0; k < N; k++) nz |= (mem[k] != '0);
        return (x == mem[N-1]) && nz;
    endfunction

    task automatic fill_rand(input bit good);
        logic [DW-1:0] x = '0;
        for (int k = 0; k < N - 1; k++) begin
            mem[k] = DW'($urandom);
            x ^= mem[k];
        end
        mem[N-1] = good ? x : DW'($urandom);
    endtask

    task automatic clear_log();
        wq_addr.delete(); wq_data.delete(); wq_cyc.delete();
        done_q.delete(); win_len.delete(); win_addr.delete();
    endtask

    // Runs one load from the current mem image and checks its write/read sequence
    task automatic do_load(input int drop_at, input bit hold);
        bit got = 0;
        @(posedge clk); #1;
        clear_log();
        bus.i_efuse_load_req = 1'b1;
        t0 = cyc;
        for (int c = 0; c < 200 && !got; c++) begin
            @(negedge clk);
            if (bus.o_efuse_load_done) got = 1;
            @(posedge clk); #1;
            if (cyc - t0 == drop_at) bus.i_efuse_load_req = 1'b0;
            if (got && !hold) bus.i_efuse_load_req = 1'b0;
        end
        n_chk++;
        if (!got) begin
            n_fail++;
            $display("FAIL load_timeout: done not seen within 200 cycles");
        end
        n_chk++;
        if (wq_addr.size() !== N - 1) begin
            n_fail++;
            $display("FAIL write_count: got %0d, expected %0d", wq_addr.size(), N - 1);
        end
        for (int k = 0; k < N - 1 && k < wq_addr.size(); k++) begin
            n_chk++;
            if (wq_addr[k] !== k || wq_data[k] !== int'(mem[k]) || wq_cyc[k] !== (k + 1) * (W + 1)) begin
                n_fail++;
                $display("FAIL write_%0d: got addr %0d data %0h cycle %0d, expected addr %0d data %0h cycle %0d",
                         k, wq_addr[k], wq_data[k], wq_cyc[k], k, mem[k], (k + 1) * (W + 1));
            end
        end
        n_chk++;
        if (win_len.size() !== N) begin
            n_fail++;
            $display("FAIL read_windows: got %0d, expected %0d", win_len.size(), N);
        end
        for (int k = 0; k < N && k < win_len.size(); k++) begin
            n_chk++;
            if (win_len[k] !== W || win_addr[k] !== k) begin
                n_fail++;
                $display("FAIL read_window_%0d: got len %0d addr %0d, expected len %0d addr %0d",
                         k, win_len[k], win_addr[k], W, k);
            end
        end
        n_chk++;
        if (done_q.size() < 1 || done_q[0] !== T_DONE) begin
            n_fail++;
            $display("FAIL done_cycle: got %0d, expected %0d", done_q.size() ? done_q[0] : -1, T_DONE);
        end
    endtask

    task automatic test_reset();
        bus.i_efuse_load_req = 1'b0;
        #3;
        n_chk++;
        if (outs !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h, expected 0", outs);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_nominal(input logic [DW-1:0] cks);
        logic [DW-1:0] v [N] = '{8'h11, 8'h22, 8'h44, 8'h88, 8'h01, 8'h02, 8'h04, 8'h00};
        v[N-1] = cks;
        mem = v;
        do_load(-1, 0);
        n_chk++;
        if (done_vld !== exp_vld()) begin
            n_fail++;
            $display("FAIL vld_cks_%h: got %b, expected %b", cks, done_vld, exp_vld());
        end
        repeat (3) @(negedge clk);
        n_chk++;
        if (bus.o_efuse_vld !== exp_vld() || bus.o_efuse_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL vld_hold_%h: got vld %b busy %b, expected vld %b busy 0",
                     cks, bus.o_efuse_vld, bus.o_efuse_busy, exp_vld());
        end
    endtask

    task automatic test_blank();
        for (int k = 0; k < N; k++) mem[k] = '0;
        do_load(-1, 0);
        n_chk++;
        if (done_vld !== 1'b0) begin
            n_fail++;
            $display("FAIL blank_vld: got %b, expected 0", done_vld);
        end
    endtask

    task automatic test_req_drop();
        fill_rand(1);
        do_load(12, 0);
        n_chk++;
        if (done_vld !== exp_vld()) begin
            n_fail++;
            $display("FAIL drop_vld: got %b, expected %b", done_vld, exp_vld());
        end
        repeat (10) @(negedge clk);
        n_chk++;
        if (done_q.size() !== 1 || bus.o_efuse_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL drop_restart: got %0d dones busy %b, expected 1 done busy 0",
                     done_q.size(), bus.o_efuse_busy);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 6; i++) begin
            fill_rand(bit'($urandom_range(0, 1)));
            do_load(-1, 0);
            n_chk++;
            if (done_vld !== exp_vld()) begin
                n_fail++;
                $display("FAIL rand_vld_%0d: got %b, expected %b", i, done_vld, exp_vld());
            end
        end
    endtask

    task automatic test_reset_mid_load();
        test_nominal(8'hF8);
        @(posedge clk); #1;
        clear_log();
        bus.i_efuse_load_req = 1'b1;
        t0 = cyc;
        while (cyc - t0 < 20) begin
            @(posedge clk); #1;
        end
        n_chk++;
        if (bus.o_efuse_busy !== 1'b1 || wq_addr.size() !== 3) begin
            n_fail++;
            $display("FAIL pre_reset: got busy %b writes %0d, expected busy 1 writes 3",
                     bus.o_efuse_busy, wq_addr.size());
        end
        rst_n = 1'b0;
        bus.i_efuse_load_req = 1'b0;
        #1;
        n_chk++;
        if (outs !== '0) begin
            n_fail++;
            $display("FAIL mid_reset_outputs: got %h, expected 0", outs);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        fill_rand(1);
        do_load(-1, 0);
        n_chk++;
        if (done_vld !== exp_vld()) begin
            n_fail++;
            $display("FAIL post_reset_vld: got %b, expected %b", done_vld, exp_vld());
        end
    endtask

    task automatic test_back_to_back();
        bit got = 0;
        logic first_vld;
        fill_rand(1);
        do_load(-1, 1);
        first_vld = done_vld;
        @(negedge clk);
        n_chk++;
        if (bus.o_efuse_vld !== exp_vld()) begin
            n_fail++;
            $display("FAIL b2b_idle_vld: got %b, expected %b", bus.o_efuse_vld, exp_vld());
        end
        @(negedge clk);
        n_chk++;
        if (bus.o_efuse_vld !== 1'b0 || bus.o_efuse_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_restart: got vld %b busy %b, expected vld 0 busy 1",
                     bus.o_efuse_vld, bus.o_efuse_busy);
        end
        for (int c = 0; c < 200 && !got; c++) begin
            @(negedge clk);
            if (bus.o_efuse_load_done) got = 1;
        end
        @(posedge clk); #1;
        bus.i_efuse_load_req = 1'b0;
        n_chk++;
        if (done_q.size() !== 2 || done_q[1] - done_q[0] !== T_DONE + 1) begin
            n_fail++;
            $display("FAIL b2b_done_gap: got %0d dones gap %0d, expected 2 dones gap %0d",
                     done_q.size(), done_q.size() == 2 ? done_q[1] - done_q[0] : -1, T_DONE + 1);
        end
        n_chk++;
        if (first_vld !== exp_vld() || done_vld !== exp_vld()) begin
            n_fail++;
            $display("FAIL b2b_vld: got %b/%b, expected %b", first_vld, done_vld, exp_vld());
        end
        repeat (5) @(negedge clk);
        n_chk++;
        if (bus.o_efuse_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_no_third: got busy %b, expected 0", bus.o_efuse_busy);
        end
    endtask

    initial begin
        test_reset();
        test_nominal(8'hF8);
        test_nominal(8'hF9);
        test_blank();
        test_req_drop();
        test_random();
        test_reset_mid_load();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
